// File: rtl/mem_seq_pkg.sv
// mem_sequencer shared types: FSM states, fault causes,
// request kinds and IR field positions used by Control.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic CAUSE_MISALIGN = 1'b0;
  localparam logic CAUSE_RANGE    = 1'b1;

  localparam logic KIND_IFETCH = 1'b0;
  localparam logic KIND_DATA   = 1'b1;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 0;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/mem_seq_if.sv
// Request, memory and register-bank bundle between Control,
// the sequencer and the synchronous memory.
interface mem_seq_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              req_we;
  logic              req_kind;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              busy;
  logic              done;
  logic              fault;
  logic              fault_cause;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] ir;
  logic [5:0]        OP;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [5:0]        Funct;
  logic [15:0]       imm;
  logic [DATA_W-1:0] mdr;

  modport slave (
    input  req, req_we, req_kind,
    input  req_addr, req_wdata, mem_rdata,
    output busy, done, fault, fault_cause,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output ir, OP, rs, rt, rd, Funct, imm, mdr
  );

  modport master (
    output req, req_we, req_kind,
    output req_addr, req_wdata, mem_rdata,
    input  busy, done, fault, fault_cause,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  ir, OP, rs, rt, rd, Funct, imm, mdr
  );
endinterface

// File: rtl/mem_sequencer.sv
// Single-outstanding memory access sequencer with IR/MDR bank.
// Outputs are registered from the next state so they align with it.
module mem_sequencer #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 2,
  parameter int MEM_WORDS = 256
) (
  input logic      clk,
  input logic      Reset,
  mem_seq_if.slave bus
);
  import mem_seq_pkg::*;

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [ADDR_W-3:0] W_LIM =
    (ADDR_W-2)'(MEM_WORDS);

  state_t r_state;
  state_t w_state_n;

  logic              r_we;
  logic              r_kind;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_n;

  logic              r_busy;
  logic              r_done;
  logic              r_fault;
  logic              r_cause;
  logic              w_cause_n;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_mdr;

  logic              w_lat;
  logic              w_misal;
  logic              w_oor;
  logic              w_cap;
  logic              w_sel;
  logic              w_we_n;
  logic [ADDR_W-1:0] w_addr_n;
  logic [DATA_W-1:0] w_wdata_n;

  assign w_lat   = (r_state == S_IDLE) && bus.req;
  assign w_misal = |bus.req_addr[1:0];
  assign w_oor   = bus.req_addr[ADDR_W-1:2] >= W_LIM;

  assign w_we_n    = w_lat ? bus.req_we    : r_we;
  assign w_addr_n  = w_lat ? bus.req_addr  : r_addr;
  assign w_wdata_n = w_lat ? bus.req_wdata : r_wdata;
  assign w_sel     = (w_state_n == S_ISSUE) ||
                     (w_state_n == S_WAIT);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_cause_n = r_cause;
    w_cap     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.req) begin
          if (w_misal) begin
            w_state_n = S_FAULT;
            w_cause_n = CAUSE_MISALIGN;
          end else if (w_oor) begin
            w_state_n = S_FAULT;
            w_cause_n = CAUSE_RANGE;
          end else begin
            w_state_n = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (r_we) begin
          w_state_n = S_DONE;
        end else begin
          w_state_n = S_WAIT;
          w_cnt_n   = CW'(MEM_LAT - 1);
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_cap     = 1'b1;
          w_state_n = S_DONE;
        end else begin
          w_cnt_n = r_cnt - 1'b1;
        end
      end
      S_DONE:  w_state_n = S_IDLE;
      S_FAULT: w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_we        <= 1'b0;
      r_kind      <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_cause     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ir        <= '0;
      r_mdr       <= '0;
    end else begin
      if (w_lat) begin
        r_we    <= bus.req_we;
        r_kind  <= bus.req_kind;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
      end
      r_cnt       <= w_cnt_n;
      r_cause     <= w_cause_n;
      r_busy      <= w_state_n != S_IDLE;
      r_done      <= (w_state_n == S_DONE) ||
                     (w_state_n == S_FAULT);
      r_fault     <= w_state_n == S_FAULT;
      r_mem_en    <= w_state_n == S_ISSUE;
      r_mem_we    <= (w_state_n == S_ISSUE) && w_we_n;
      r_mem_addr  <= w_sel ? w_addr_n  : '0;
      r_mem_wdata <= w_sel ? w_wdata_n : '0;
      // stores never reach WAIT, so kind 0 stores leave IR alone
      if (w_cap) begin
        if (r_kind == KIND_IFETCH) r_ir  <= bus.mem_rdata;
        else                       r_mdr <= bus.mem_rdata;
      end
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.fault       = r_fault;
  assign bus.fault_cause = r_cause;
  assign bus.mem_en      = r_mem_en;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.ir          = r_ir;
  assign bus.mdr         = r_mdr;
  assign bus.OP          = r_ir[OP_MSB:OP_LSB];
  assign bus.rs          = r_ir[RS_MSB:RS_LSB];
  assign bus.rt          = r_ir[RT_MSB:RT_LSB];
  assign bus.rd          = r_ir[RD_MSB:RD_LSB];
  assign bus.Funct       = r_ir[FN_MSB:FN_LSB];
  assign bus.imm         = r_ir[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_mem_sequencer.sv
// Bench for mem_sequencer: two instances (MEM_LAT 2 and 1) over
// one shared memory model, expectations queued per request.
module tb_mem_sequencer;
  import mem_seq_pkg::*;

  typedef struct {
    int          lat;
    logic        flt;
    logic        cause;
    logic [31:0] ir;
    logic [31:0] mdr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_seq_if #(.ADDR_W(32), .DATA_W(32)) b2 ();
  mem_seq_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

  mem_sequencer #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .MEM_WORDS(256)
  ) dut2 (.clk(clk), .Reset(rst_n), .bus(b2));

  mem_sequencer #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MEM_WORDS(256)
  ) dut1 (.clk(clk), .Reset(rst_n), .bus(b1));

  logic [31:0] mem [256];
  logic [31:0] p2a, p2b, p1a;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_a = '0;
  logic [31:0] pl_d = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    if (b2.mem_en) begin
      if (b2.mem_we) mem[b2.mem_addr[9:2]] <= b2.mem_wdata;
      p2a <= mem[b2.mem_addr[9:2]];
    end
    p2b <= p2a;
    if (b1.mem_en) begin
      if (b1.mem_we) mem[b1.mem_addr[9:2]] <= b1.mem_wdata;
      p1a <= mem[b1.mem_addr[9:2]];
    end
  end
  assign b2.mem_rdata = p2b;
  assign b1.mem_rdata = p1a;

  int errors = 0;
  int checks = 0;
  exp_t q[$];
  logic [31:0] m_mem [256];
  logic [31:0] m_ir = '0;
  logic [31:0] m_mdr = '0;

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    pl_en = 1'b1;
    pl_a  = a[9:2];
    pl_d  = d;
    m_mem[a[9:2]] = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic predict(input logic we, input logic kind,
                         input logic [31:0] a,
                         input logic [31:0] d, input int lat);
    exp_t e;
    e.flt = 1'b0;
    e.cause = 1'b0;
    if (a[1:0] != 2'b00) begin
      e.flt = 1'b1;
      e.cause = 1'b0;
      e.lat = 1;
    end else if (a[31:2] >= 30'd256) begin
      e.flt = 1'b1;
      e.cause = 1'b1;
      e.lat = 1;
    end else if (we) begin
      m_mem[a[9:2]] = d;
      e.lat = 2;
    end else begin
      e.lat = 2 + lat;
      if (kind == 1'b0) m_ir = m_mem[a[9:2]];
      else              m_mdr = m_mem[a[9:2]];
    end
    e.ir = m_ir;
    e.mdr = m_mdr;
    q.push_back(e);
  endtask

  task automatic go(input logic we, input logic kind,
                    input logic [31:0] a, input logic [31:0] d,
                    input bit hold, output int cyc,
                    output int en, output logic f,
                    output logic c);
    b2.req = 1'b1;
    b2.req_we = we;
    b2.req_kind = kind;
    b2.req_addr = a;
    b2.req_wdata = d;
    @(posedge clk);
    #1;
    if (!hold) b2.req = 1'b0;
    cyc = 1;
    en = int'(b2.mem_en);
    while (!b2.done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      en += int'(b2.mem_en);
    end
    f = b2.fault;
    c = b2.fault_cause;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (b2.busy !== 1'b0 || b2.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_done got %b%b want 00",
               b2.busy, b2.done);
    end
    checks++;
    if (b2.mem_en !== 1'b0 || b2.mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem got en=%b addr=%h want 0 0",
               b2.mem_en, b2.mem_addr);
    end
    checks++;
    if (b2.ir !== 32'h0 || b2.mdr !== 32'h0 ||
        b1.ir !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs got ir=%h mdr=%h ir1=%h want 0",
               b2.ir, b2.mdr, b1.ir);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_fetch();
    int cyc, en;
    logic f, c;
    exp_t e;
    poke(32'h10, 32'h8C220004);
    predict(1'b0, KIND_IFETCH, 32'h10, 32'h0, 2);
    go(1'b0, KIND_IFETCH, 32'h10, 32'h0, 1'b0, cyc, en, f, c);
    e = q.pop_front();
    checks++;
    if (cyc !== e.lat || f !== 1'b0) begin
      errors++;
      $display("FAIL fetch_done got cyc=%0d f=%b want %0d 0",
               cyc, f, e.lat);
    end
    checks++;
    if (en !== 1) begin
      errors++;
      $display("FAIL fetch_mem_en got %0d want 1", en);
    end
    checks++;
    if (b2.ir !== e.ir || b2.mdr !== e.mdr) begin
      errors++;
      $display("FAIL fetch_ir got %h/%h want %h/%h",
               b2.ir, b2.mdr, e.ir, e.mdr);
    end
    checks++;
    if (b2.OP !== 6'h23 || b2.rt !== 5'd2 ||
        b2.imm !== 16'h4) begin
      errors++;
      $display("FAIL fetch_fields got op=%h rt=%0d imm=%h",
               b2.OP, b2.rt, b2.imm);
    end
    idle();
  endtask

  task automatic test_store_load();
    int cyc, en;
    logic f, c;
    exp_t e;
    predict(1'b1, KIND_DATA, 32'h20, 32'hDEADBEEF, 2);
    go(1'b1, KIND_DATA, 32'h20, 32'hDEADBEEF, 1'b0,
       cyc, en, f, c);
    e = q.pop_front();
    checks++;
    if (cyc !== e.lat || en !== 1) begin
      errors++;
      $display("FAIL store_done got cyc=%0d en=%0d want %0d 1",
               cyc, en, e.lat);
    end
    idle();
    predict(1'b1, KIND_IFETCH, 32'h24, 32'h12345678, 2);
    go(1'b1, KIND_IFETCH, 32'h24, 32'h12345678, 1'b0,
       cyc, en, f, c);
    e = q.pop_front();
    checks++;
    if (cyc !== e.lat || b2.ir !== e.ir) begin
      errors++;
      $display("FAIL store_k0 got cyc=%0d ir=%h want %0d %h",
               cyc, b2.ir, e.lat, e.ir);
    end
    idle();
    predict(1'b0, KIND_DATA, 32'h20, 32'h0, 2);
    go(1'b0, KIND_DATA, 32'h20, 32'h0, 1'b0, cyc, en, f, c);
    e = q.pop_front();
    checks++;
    if (cyc !== e.lat || b2.mdr !== e.mdr ||
        b2.ir !== e.ir) begin
      errors++;
      $display("FAIL load_mdr got cyc=%0d mdr=%h ir=%h want %0d %h %h",
               cyc, b2.mdr, b2.ir, e.lat, e.mdr, e.ir);
    end
    idle();
  endtask

  task automatic test_faults();
    logic [31:0] addrs [4];
    int cyc, en;
    logic f, c;
    exp_t e;
    addrs[0] = 32'h22;
    addrs[1] = 32'h400;
    addrs[2] = 32'h402;
    addrs[3] = 32'h3FC;
    for (int i = 0; i < 4; i++) begin
      predict(1'b0, 1'(i % 2), addrs[i], 32'h0, 2);
      go(1'b0, 1'(i % 2), addrs[i], 32'h0, 1'b0,
         cyc, en, f, c);
      e = q.pop_front();
      checks++;
      if (cyc !== e.lat || f !== e.flt ||
          (e.flt && c !== e.cause)) begin
        errors++;
        $display("FAIL fault_%h got cyc=%0d f=%b c=%b want %0d %b %b",
                 addrs[i], cyc, f, c, e.lat, e.flt, e.cause);
      end
      checks++;
      if (en !== (e.flt ? 0 : 1) || b2.ir !== e.ir ||
          b2.mdr !== e.mdr) begin
        errors++;
        $display("FAIL fault_side_%h got en=%0d ir=%h mdr=%h",
                 addrs[i], en, b2.ir, b2.mdr);
      end
      idle();
    end
  endtask

  task automatic test_abort();
    int cyc, en;
    logic f, c;
    exp_t e;
    b2.req = 1'b1;
    b2.req_we = 1'b0;
    b2.req_kind = KIND_IFETCH;
    b2.req_addr = 32'h10;
    @(posedge clk);
    #1 b2.req = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (b2.mem_en !== 1'b0 || b2.busy !== 1'b0 ||
        b2.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_ctl got en=%b busy=%b done=%b want 000",
               b2.mem_en, b2.busy, b2.done);
    end
    checks++;
    if (b2.ir !== 32'h0 || b2.mdr !== 32'h0) begin
      errors++;
      $display("FAIL abort_regs got ir=%h mdr=%h want 0 0",
               b2.ir, b2.mdr);
    end
    m_ir = '0;
    m_mdr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle();
    predict(1'b0, KIND_IFETCH, 32'h10, 32'h0, 2);
    go(1'b0, KIND_IFETCH, 32'h10, 32'h0, 1'b0, cyc, en, f, c);
    e = q.pop_front();
    checks++;
    if (cyc !== e.lat || b2.ir !== e.ir) begin
      errors++;
      $display("FAIL abort_refetch got cyc=%0d ir=%h want %0d %h",
               cyc, b2.ir, e.lat, e.ir);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    int cyc, en;
    logic f, c;
    exp_t e;
    predict(1'b0, KIND_DATA, 32'h10, 32'h0, 2);
    go(1'b0, KIND_DATA, 32'h10, 32'h0, 1'b1, cyc, en, f, c);
    e = q.pop_front();
    checks++;
    if (cyc !== e.lat || en !== 1 || b2.mdr !== e.mdr) begin
      errors++;
      $display("FAIL held_first got cyc=%0d en=%0d mdr=%h want %0d 1 %h",
               cyc, en, b2.mdr, e.lat, e.mdr);
    end
    @(posedge clk);
    #1;
    checks++;
    if (b2.busy !== 1'b0 || b2.mem_en !== 1'b0) begin
      errors++;
      $display("FAIL held_idle got busy=%b en=%b want 0 0",
               b2.busy, b2.mem_en);
    end
    predict(1'b0, KIND_DATA, 32'h10, 32'h0, 2);
    @(posedge clk);
    #1 b2.req = 1'b0;
    checks++;
    if (b2.mem_en !== 1'b1) begin
      errors++;
      $display("FAIL held_second_issue got en=%b want 1",
               b2.mem_en);
    end
    cyc = 1;
    while (!b2.done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    e = q.pop_front();
    checks++;
    if (cyc !== e.lat || b2.mdr !== e.mdr) begin
      errors++;
      $display("FAIL held_second got cyc=%0d mdr=%h want %0d %h",
               cyc, b2.mdr, e.lat, e.mdr);
    end
    idle();
  endtask

  task automatic test_lat1();
    int cyc;
    exp_t e;
    poke(32'h30, 32'h012A4020);
    e.lat = 3;
    e.flt = 1'b0;
    e.cause = 1'b0;
    e.ir = m_mem[12];
    e.mdr = 32'h0;
    q.push_back(e);
    b1.req = 1'b1;
    b1.req_we = 1'b0;
    b1.req_kind = KIND_IFETCH;
    b1.req_addr = 32'h30;
    @(posedge clk);
    #1 b1.req = 1'b0;
    cyc = 1;
    while (!b1.done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    e = q.pop_front();
    checks++;
    if (cyc !== e.lat || b1.ir !== e.ir) begin
      errors++;
      $display("FAIL lat1_fetch got cyc=%0d ir=%h want %0d %h",
               cyc, b1.ir, e.lat, e.ir);
    end
    checks++;
    if (b1.rs !== 5'd9 || b1.rd !== 5'd8 ||
        b1.Funct !== 6'h20) begin
      errors++;
      $display("FAIL lat1_fields got rs=%0d rd=%0d fn=%h",
               b1.rs, b1.rd, b1.Funct);
    end
    idle();
  endtask

  initial begin
    b2.req = 1'b0;
    b2.req_we = 1'b0;
    b2.req_kind = 1'b0;
    b2.req_addr = '0;
    b2.req_wdata = '0;
    b1.req = 1'b0;
    b1.req_we = 1'b0;
    b1.req_kind = 1'b0;
    b1.req_addr = '0;
    b1.req_wdata = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    test_reset();
    test_fetch();
    test_store_load();
    test_faults();
    test_abort();
    test_back_to_back();
    test_lat1();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
